// File: rtl/cory_pack.sv
// cory_pack: packs up to M narrow N-bit beats into one M*N-bit word with beat count and last flag.
// Optional idle flush of a partial word is enabled with `define CORY_PACK_TIMEOUT_EN (parameter T).
module cory_pack #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int CW = 3
`ifdef CORY_PACK_TIMEOUT_EN
    ,
    parameter int T  = 16
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_a_v,
    input  logic [N-1:0]    i_a_d,
    input  logic            i_a_last,
    output logic            o_a_r,
    output logic            o_z_v,
    output logic [M*N-1:0]  o_z_d,
    output logic [CW-1:0]   o_z_cnt,
    output logic            o_z_last,
    input  logic            i_z_r
);

    logic [M*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           z_v_q, z_v_d;
    logic [M*N-1:0] z_d_q, z_d_d;
    logic [CW-1:0]  z_cnt_q, z_cnt_d;
    logic           z_last_q, z_last_d;

    logic           completing;
    logic           out_free;
    logic           accept;
    logic           flush;
    logic [M*N-1:0] merged;

    assign completing = i_a_last | (cnt_q == CW'(M - 1));
    assign out_free   = ~z_v_q | i_z_r;
    assign o_a_r      = i_a_v & (~completing | out_free) & ~flush;
    assign accept     = i_a_v & o_a_r;

`ifdef CORY_PACK_TIMEOUT_EN
    localparam int IW = $clog2(T + 1);
    logic [IW-1:0] idle_q, idle_d;

    // Counter saturates at T so a blocked flush fires as soon as the output frees up.
    assign flush = (idle_q == IW'(T)) & (cnt_q != '0) & out_free;

    always_comb begin
        idle_d = idle_q;
        if (accept || flush || cnt_q == '0) begin
            idle_d = '0;
        end else if (idle_q != IW'(T)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        merged = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (CW'(k) < cnt_q) begin
                merged[k*N +: N] = acc_q[k*N +: N];
            end else if (CW'(k) == cnt_q) begin
                merged[k*N +: N] = i_a_d;
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        z_v_d    = z_v_q;
        z_d_d    = z_d_q;
        z_cnt_d  = z_cnt_q;
        z_last_d = z_last_q;
        if (z_v_q && i_z_r) begin
            z_v_d = 1'b0;
        end
        if (flush) begin
            z_v_d    = 1'b1;
            z_d_d    = acc_q;
            z_cnt_d  = cnt_q;
            z_last_d = 1'b0;
            cnt_d    = '0;
            acc_d    = '0;
        end else if (accept) begin
            if (completing) begin
                z_v_d    = 1'b1;
                z_d_d    = merged;
                z_cnt_d  = cnt_q + 1'b1;
                z_last_d = i_a_last;
                cnt_d    = '0;
                acc_d    = '0;
            end else begin
                acc_d[cnt_q*N +: N] = i_a_d;
                cnt_d               = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            z_v_q    <= 1'b0;
            z_d_q    <= '0;
            z_cnt_q  <= '0;
            z_last_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            z_v_q    <= z_v_d;
            z_d_q    <= z_d_d;
            z_cnt_q  <= z_cnt_d;
            z_last_q <= z_last_d;
        end
    end

    assign o_z_v    = z_v_q;
    assign o_z_d    = z_d_q;
    assign o_z_cnt  = z_cnt_q;
    assign o_z_last = z_last_q;

endmodule

// File: doc/cory_pack.md
Name: cory_pack

Overview:
- Downstream neighbour of the repeat stage.
- Consumes a narrow valid/ready stream with a per-beat last flag, such as the repeat stage's z output.
- Packs up to M consecutive N-bit beats into one M*N-bit word and emits it with a beat count and a last flag.
- Used where repeated narrow data feeds a wide bus or memory write port.

Parameters:
N, 8, input beat width in bits
M, 4, beats per packed output word (M >= 2)
CW, 3, width of o_z_cnt; must satisfy 2^CW > M

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  reset, asynchronous, active-low
i_a_v  input  1  input beat valid
i_a_d  input  N  input beat data
i_a_last  input  1  input beat closes the current group
o_a_r  output  1  input ready
o_z_v  output  1  packed word valid
o_z_d  output  M*N  packed word; beat k occupies bits [k*N +: N]
o_z_cnt  output  CW  number of valid beats in o_z_d, 1..M
o_z_last  output  1  word was closed by i_a_last
i_z_r  input  1  output ready

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous, active-low.
- Storage:
  - Accumulation register acc (M*N bits) with slot counter cnt (0..M-1).
  - Separate output register holding o_z_v, o_z_d, o_z_cnt, o_z_last.
- Reset values: cnt=0; acc=0; o_z_v=0; o_z_d=0; o_z_cnt=0; o_z_last=0.
- Input acceptance: a beat is accepted when i_a_v & o_a_r.
- Completing beat: an accepted beat with i_a_last=1 or cnt==M-1.
- o_a_r = i_a_v & (!completing | !o_z_v | i_z_r).
  - Non-completing beats are always accepted.
  - A completing beat waits only if the output register is occupied and not draining.
- Non-completing accept: acc slot cnt <= i_a_d; cnt <= cnt+1.
- Completing accept:
  - o_z_d <= acc with slot cnt replaced by i_a_d and slots above cnt forced to 0.
  - o_z_cnt <= cnt+1.
  - o_z_last <= i_a_last.
  - o_z_v <= 1.
  - cnt <= 0; acc <= 0.
- Latency: a completing beat accepted in cycle t appears on o_z in cycle t+1.
- Output handshake:
  - o_z_v & i_z_r with no new completing accept -> o_z_v <= 0; o_z_d/cnt/last hold their values.
  - Drain and a new completing accept in the same cycle -> the register reloads; o_z_v stays 1. This gives full throughput of one word per cycle.
- Boundaries:
  - i_a_last on slot M-1: one word, o_z_cnt=M, o_z_last=1.
  - i_a_last on slot 0: o_z_cnt=1, upper slots 0.
  - Full word without last: o_z_last=0; the next beat starts slot 0 of a new word in the same group.
- Output stability: while o_z_v=1 and i_z_r=0, all o_z_* are stable.
- Reset mid-group: the partial acc is discarded; no word is emitted.

Optional Feature:
- Macro: CORY_PACK_TIMEOUT_EN. Adds parameter T (default 16) and an idle counter of width $clog2(T+1).
- With the macro defined:
  - The idle counter increments each cycle that cnt!=0 and no beat is accepted.
  - It clears on any accept and on reset.
  - When it reaches T and the output register is free (!o_z_v | i_z_r), the partial word flushes exactly as a completing accept would, but without new data: o_z_cnt=cnt, o_z_last=0.
  - Flush and input accept never coincide: a flush has priority, and o_a_r is 0 in the flush cycle.
- Without the macro: a partial word is held indefinitely until more beats arrive.

Test Plan:
- M=4. Beats 0x11,0x22,0x33,0x44, last on 0x44, i_z_r=1 -> one cycle after the 4th accept: o_z_d=0x44332211, o_z_cnt=4, o_z_last=1.
- Beats 0xA1,0xA2, last on 0xA2 -> o_z_d=0x0000A2A1, o_z_cnt=2, o_z_last=1.
- Six beats 1..6, last on 6 -> first word 0x04030201 with cnt=4, last=0; second word 0x00000605 with cnt=2, last=1.
- i_z_r=0 for 5 cycles with a word pending -> 3 more beats are accepted; the next completing beat sees o_a_r=0; o_z_* stay stable; when i_z_r rises, drain and reload happen in one cycle.
- Continuous input with i_z_r=1 -> o_a_r held at 1, one word every M cycles. Assert reset_n low after 2 beats -> o_z_v=0, cnt=0, no word emitted.
- CORY_PACK_TIMEOUT_EN, T=4: one beat 0x55, then idle -> after 4 idle cycles, a word appears one cycle later with o_z_d=0x00000055, cnt=1, last=0.
